polyveck_t1_pack: RTL and testbench
===================================

Name: polyveck_t1_pack

Overview:
- Sequential serializer directly downstream of the power2round stage.
- Captures the full K-poly t1 vector (linear_v1 format) on a start pulse and emits it as the Dilithium polyt1_pack byte stream: 4 coefficients × 10 bits → 5 bytes, 320 bytes/poly, 1920 bytes total.
- Output uses a valid/ready handshake and feeds the public-key assembly / SHAKE absorb path.

Parameters:
- K, 6, number of polynomials in the vector.
- N, 256, coefficients per polynomial.
- T1_BITS, 10, packed width per coefficient.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle request; sampled only in IDLE.
- linear_t1  input  49152  t1 vector. Poly x occupies [8192x+8191:8192x]; coefficient i of a poly occupies [32i+31:32i] of that slice.
- busy  output  1  high from the accepted start until the final byte transfer.
- out_data  output  8  current packed byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte.
- out_last  output  1  high with byte 1919 only.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (async assert, clocked release): state IDLE; busy=0, out_valid=0, out_last=0, done=0, out_data=0; all counters 0. Capture register contents don't-care.
- IDLE, start=1:
  - Capture the low T1_BITS of every coefficient into a 15360-bit register. Upper 22 bits are ignored.
  - Clear counters and go to STREAM.
  - Cycle n start → cycle n+1: busy=1, out_valid=1, out_data=byte 0.
- STREAM:
  - Byte index b = 0..1919, tracked as three counters: poly p (0..K-1), group g (0..63), byte k (0..4).
  - Group value G = {c[4g+3], c[4g+2], c[4g+1], c[4g]} (40 bits, c[4g] in bits 9:0).
  - out_data = G[8k+7:8k].
  - Transfer occurs when out_valid && out_ready. On transfer, advance k; k wraps 4→0 and increments g; g wraps 63→0 and increments p.
  - While out_valid && !out_ready, out_data, out_valid and out_last hold stable. No bubbles: a transfer every cycle when out_ready stays high, so 1920 cycles for the full stream.
- Transfer with out_last=1 (p=K-1, g=63, k=4):
  - Next cycle: out_valid=0, busy=0, done=1 for exactly one cycle, state IDLE.
  - A start in that same cycle is accepted (done and the new busy coexist).
- start while busy: ignored; the capture register is unchanged.
- linear_t1 changing after capture: no effect on the stream in progress.
- Reset asserted mid-stream: immediate return to reset values. No done pulse; the partial stream is abandoned.
- All arithmetic is unsigned. Coefficients are treated as unsigned 10-bit fields regardless of the signed port type.

Decomposition:
- Shared package (dilithium_params): K, N, D=13, T1_BITS=10, POLYT1_PACKEDBYTES=320, PK_T1_BYTES=1920, COEF_W=32, POLY_W=8192.
- Natural sub-module: polyt1_byte_sel.
  - Combinational.
  - Inputs: 4×10-bit coefficients and k.
  - Output: the selected byte.
- The top level holds the FSM, counters and capture register, and muxes the 4 coefficients addressed by (p, g).

Test Plan:
1. All zero except poly0 coef0=0x3FF, out_ready=1 → bytes 0,1 = 0xFF,0x03; bytes 2..1919 = 0x00; out_last on byte 1919; done one cycle later; 1920 transfers in 1920 cycles.
2. Poly0 coef1=0x3FF, coef3=0x3FF, others 0 → bytes 1..4 = 0xFC,0x0F,0xC0,0xFF.
3. Poly5 coef255=0x201 → byte 1918 = 0x40, byte 1919 = 0x80 with out_last=1; poly boundary at byte 320 checked with poly1 coef0=0x155 → byte 320 = 0x55, byte 321 = 0x01.
4. Coefficient slots holding 0xFFFFFC00 (upper bits set, low 10 bits zero) → all bytes 0x00.
5. Random t1 with random out_ready toggling → bytes match a golden polyt1_pack model; data stable during stalls; start pulses during busy ignored.
6. Reset asserted at byte 700 → outputs zero asynchronously, no done; a new start then streams from byte 0 with new data.

Source files
------------

// File: rtl/polyveck_t1_pack_pkg.sv
// rtl/polyveck_t1_pack_pkg.sv - shared Dilithium parameters and FSM state type
// Purpose: constants for the t1 vector packer and its state encoding.
// Ports: none (package).
package polyveck_t1_pack_pkg;
   localparam int K                  = 6;
   localparam int N                  = 256;
   localparam int D                  = 13;
   localparam int T1_BITS            = 10;
   localparam int POLYT1_PACKEDBYTES = 320;
   localparam int PK_T1_BYTES        = 1920;
   localparam int COEF_W             = 32;
   localparam int POLY_W             = 8192;

   // counter limits: poly p, 4-coef group g, byte-in-group k
   localparam logic [2:0] P_LAST = 3'(K - 1);
   localparam logic [5:0] G_LAST = 6'd63;
   localparam logic [2:0] K_LAST = 3'd4;

   typedef enum logic {
      S_IDLE,
      S_STREAM
   } state_t;
endpackage

// File: rtl/polyveck_t1_pack_if.sv
// rtl/polyveck_t1_pack_if.sv - packed-byte output stream interface
// Purpose: groups the byte stream handshake.
// Ports: out_data[7:0], out_valid, out_last (master drives), out_ready (slave drives).
interface polyveck_t1_pack_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/polyveck_t1_pack_byte_sel.sv
// rtl/polyveck_t1_pack_byte_sel.sv - selects one byte of a 40-bit coefficient group
// Purpose: combinational polyt1 byte select; 4 x 10-bit coefs form a 40-bit group.
// Ports: i_c0..i_c3 coefficients (i_c0 in group bits 9:0), i_k byte index 0..4,
//        o_byte selected byte.
module polyveck_t1_pack_byte_sel
   import polyveck_t1_pack_pkg::*;
(
   input  logic [T1_BITS-1:0] i_c0,
   input  logic [T1_BITS-1:0] i_c1,
   input  logic [T1_BITS-1:0] i_c2,
   input  logic [T1_BITS-1:0] i_c3,
   input  logic [2:0]         i_k,
   output logic [7:0]         o_byte
);
   logic [4*T1_BITS-1:0] w_grp;

   assign w_grp = {i_c3, i_c2, i_c1, i_c0};

   always_comb begin
      o_byte = 8'h00;
      case (i_k)
         3'd0:    o_byte = w_grp[7:0];
         3'd1:    o_byte = w_grp[15:8];
         3'd2:    o_byte = w_grp[23:16];
         3'd3:    o_byte = w_grp[31:24];
         3'd4:    o_byte = w_grp[39:32];
         default: o_byte = 8'h00;
      endcase
   end
endmodule

// File: rtl/polyveck_t1_pack.sv
// rtl/polyveck_t1_pack.sv - serializes the K-poly t1 vector into the polyt1_pack byte stream
// Purpose: captures low 10 bits of every coefficient on start, then streams 1920 bytes.
// Ports: clk, rst (async active-high), start, linear_t1[49151:0] input vector,
//        busy, done (one-cycle pulse after final byte), m_out byte stream (master).
module polyveck_t1_pack
   import polyveck_t1_pack_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [K*POLY_W-1:0]   linear_t1,
   output logic                  busy,
   output logic                  done,
   polyveck_t1_pack_if.master    m_out
);
   state_t                     r_state;
   state_t                     w_next;
   logic [K*N*T1_BITS-1:0]     r_cap;
   logic [2:0]                 r_p;
   logic [5:0]                 r_g;
   logic [2:0]                 r_k;
   logic                       r_done;
   logic                       w_accept;
   logic                       w_stream;
   logic                       w_last;
   logic                       w_xfer;
   logic [10:0]                w_cidx;
   logic [13:0]                w_bit;
   logic [4*T1_BITS-1:0]       w_grp;
   logic [7:0]                 w_byte;

   assign w_stream = (r_state == S_STREAM);
   assign w_last   = w_stream && (r_p == P_LAST) && (r_g == G_LAST) && (r_k == K_LAST);
   assign w_xfer   = w_stream && m_out.out_ready;

   // first coefficient of the group: p*256 + 4*g, a pure bit concatenation
   assign w_cidx = {r_p, r_g, 2'b00};
   assign w_bit  = {3'b000, w_cidx} * 14'd10;
   assign w_grp  = r_cap[w_bit +: 4*T1_BITS];

   polyveck_t1_pack_byte_sel u_byte_sel (
      .i_c0   (w_grp[9:0]),
      .i_c1   (w_grp[19:10]),
      .i_c2   (w_grp[29:20]),
      .i_c3   (w_grp[39:30]),
      .i_k    (r_k),
      .o_byte (w_byte)
   );

   assign m_out.out_valid = w_stream;
   assign m_out.out_last  = w_last;
   assign m_out.out_data  = w_stream ? w_byte : 8'h00;
   assign busy            = w_stream;
   assign done            = r_done;

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_STREAM;
            end
         end
         S_STREAM: begin
            if (w_xfer && w_last) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
         r_p     <= '0;
         r_g     <= '0;
         r_k     <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= w_xfer && w_last;
         if (w_accept) begin
            r_p <= '0;
            r_g <= '0;
            r_k <= '0;
         end else if (w_xfer) begin
            if (r_k == K_LAST) begin
               r_k <= '0;
               if (r_g == G_LAST) begin
                  r_g <= '0;
                  r_p <= r_p + 3'd1;
               end else begin
                  r_g <= r_g + 6'd1;
               end
            end else begin
               r_k <= r_k + 3'd1;
            end
         end
      end
   end

   // capture has no reset: its contents only matter after a start loads it
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int x = 0; x < K*N; x++) begin
            r_cap[x*T1_BITS +: T1_BITS] <= linear_t1[x*COEF_W +: T1_BITS];
         end
      end
   end
endmodule

// File: tb/tb_polyveck_t1_pack.sv
// tb/tb_polyveck_t1_pack.sv - self-checking bench for polyveck_t1_pack
module tb_polyveck_t1_pack;
   import polyveck_t1_pack_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [49151:0]    linear_t1 = '0;
   logic              busy;
   logic              done;

   polyveck_t1_pack_if u_if ();

   polyveck_t1_pack dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .linear_t1 (linear_t1),
      .busy      (busy),
      .done      (done),
      .m_out     (u_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         test;
      int         idx;
      logic [7:0] data;
      logic       last;
   } vec_t;

   vec_t       tbl[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] got[1920];
   logic       got_last[1920];
   int         cyc_used;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gold_byte(input logic [49151:0] v, input int b);
      int p, r, g, k;
      logic [39:0] grp;
      p = b / 320;
      r = b % 320;
      g = r / 5;
      k = r % 5;
      for (int j = 0; j < 4; j++) grp[10*j +: 10] = v[8192*p + 32*(4*g + j) +: 10];
      return grp[8*k +: 8];
   endfunction

   task automatic set_coef(input int p, input int i, input logic [31:0] v);
      linear_t1[8192*p + 32*i +: 32] = v;
   endtask

   task automatic fill_random();
      for (int w = 0; w < 1536; w++) linear_t1[32*w +: 32] = $urandom;
   endtask

   // Runs one full stream at the negedge; ready_pct is the out_ready duty, poke
   // injects start pulses and input changes while busy.
   task automatic run_stream(input int ready_pct, input bit poke, input string tag);
      logic [49151:0] snap;
      int nb, cyc, stall_err, last_err, mism;
      logic prev_stall, prev_last, rdy;
      logic [7:0] prev_data;
      snap = linear_t1;
      nb = 0; cyc = 0; stall_err = 0; last_err = 0; mism = 0;
      prev_stall = 1'b0; prev_last = 1'b0; prev_data = 8'h00;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
      while (nb < 1920 && cyc < 10000) begin
         if (prev_stall && (u_if.out_data !== prev_data || u_if.out_valid !== 1'b1 ||
                            u_if.out_last !== prev_last)) stall_err++;
         rdy = ($urandom_range(99) < ready_pct);
         u_if.out_ready = rdy;
         start = poke && (cyc % 97 == 5);
         if (poke && cyc == 50) fill_random();
         if (u_if.out_valid && rdy) begin
            got[nb] = u_if.out_data;
            got_last[nb] = u_if.out_last;
            if (u_if.out_last !== (nb == 1919)) last_err++;
            nb++;
         end
         prev_stall = u_if.out_valid && !rdy;
         prev_data = u_if.out_data;
         prev_last = u_if.out_last;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      u_if.out_ready = 1'b0;
      cyc_used = cyc;
      chk({tag, "_byte_count"}, nb, 32'd1920);
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
      chk({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
      chk({tag, "_valid_clear"}, {31'd0, u_if.out_valid}, 32'd0);
      for (int b = 0; b < nb; b++) if (got[b] !== gold_byte(snap, b)) mism++;
      chk({tag, "_golden_bytes"}, mism, 32'd0);
      chk({tag, "_last_flag"}, last_err, 32'd0);
      chk({tag, "_stall_stable"}, stall_err, 32'd0);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
   endtask

   task automatic apply_table(input int t);
      foreach (tbl[i]) begin
         if (tbl[i].test == t) begin
            chk($sformatf("t%0d_byte%0d", t, tbl[i].idx), {24'd0, got[tbl[i].idx]}, {24'd0, tbl[i].data});
            chk($sformatf("t%0d_last%0d", t, tbl[i].idx), {31'd0, got_last[tbl[i].idx]}, {31'd0, tbl[i].last});
         end
      end
   endtask

   initial begin
      tbl.push_back('{1, 0,    8'hFF, 1'b0});
      tbl.push_back('{1, 1,    8'h03, 1'b0});
      tbl.push_back('{1, 2,    8'h00, 1'b0});
      tbl.push_back('{1, 700,  8'h00, 1'b0});
      tbl.push_back('{1, 1919, 8'h00, 1'b1});
      tbl.push_back('{2, 0,    8'h00, 1'b0});
      tbl.push_back('{2, 1,    8'hFC, 1'b0});
      tbl.push_back('{2, 2,    8'h0F, 1'b0});
      tbl.push_back('{2, 3,    8'hC0, 1'b0});
      tbl.push_back('{2, 4,    8'hFF, 1'b0});
      tbl.push_back('{3, 319,  8'h00, 1'b0});
      tbl.push_back('{3, 320,  8'h55, 1'b0});
      tbl.push_back('{3, 321,  8'h01, 1'b0});
      tbl.push_back('{3, 1917, 8'h00, 1'b0});
      tbl.push_back('{3, 1918, 8'h40, 1'b0});
      tbl.push_back('{3, 1919, 8'h80, 1'b1});
      tbl.push_back('{4, 0,    8'h00, 1'b0});
      tbl.push_back('{4, 1,    8'h00, 1'b0});
      tbl.push_back('{4, 1919, 8'h00, 1'b1});

      u_if.out_ready = 1'b0;
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_valid", {31'd0, u_if.out_valid}, 32'd0);
      chk("reset_last", {31'd0, u_if.out_last}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_data", {24'd0, u_if.out_data}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // test 1: single max coefficient, full-rate stream
      linear_t1 = '0;
      set_coef(0, 0, 32'h3FF);
      run_stream(100, 1'b0, "t1");
      chk("t1_cycles", cyc_used, 32'd1920);
      apply_table(1);

      // test 2: coefficients 1 and 3 set
      linear_t1 = '0;
      set_coef(0, 1, 32'h3FF);
      set_coef(0, 3, 32'h3FF);
      run_stream(100, 1'b0, "t2");
      apply_table(2);

      // test 3: last coefficient and the poly0/poly1 boundary
      linear_t1 = '0;
      set_coef(5, 255, 32'h201);
      set_coef(1, 0, 32'h155);
      run_stream(100, 1'b0, "t3");
      apply_table(3);

      // test 4: upper 22 bits must be dropped
      for (int w = 0; w < 1536; w++) linear_t1[32*w +: 32] = 32'hFFFFFC00;
      run_stream(100, 1'b0, "t4");
      apply_table(4);

      // test 5: random data, random back-pressure, start and input changes while busy
      fill_random();
      run_stream(60, 1'b1, "t5");

      // test 6: reset mid-stream at byte 700
      fill_random();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      u_if.out_ready = 1'b1;
      repeat (700) @(negedge clk);
      chk("t6_busy_before_rst", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_busy", {31'd0, busy}, 32'd0);
      chk("t6_rst_valid", {31'd0, u_if.out_valid}, 32'd0);
      chk("t6_rst_data", {24'd0, u_if.out_data}, 32'd0);
      chk("t6_rst_last", {31'd0, u_if.out_last}, 32'd0);
      chk("t6_rst_done", {31'd0, done}, 32'd0);
      u_if.out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_no_done", {31'd0, done}, 32'd0);
      end
      fill_random();
      run_stream(100, 1'b0, "t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
